// File: rtl/telemetry_framer_pkg.sv
// Shared types, default delimiters and frame helpers for the telemetry framer.
package telemetry_pkg;

    // One state per byte in flight, plus IDLE between frames.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_D1  = 3'd1,
        S_D2  = 3'd2,
        S_SEQ = 3'd3,
        S_HI  = 3'd4,
        S_LO  = 3'd5,
        S_CHK = 3'd6
    } state_t;

    localparam logic [7:0] DELIM1_DEFAULT = 8'hAA;
    localparam logic [7:0] DELIM2_DEFAULT = 8'h55;

    // Bytes per frame: two delimiters, SEQ, HI/LO per channel, optional checksum.
    function automatic int unsigned frame_len(input int unsigned num_ch, input int unsigned chk_en);
        return 32'd3 + (32'd2 * num_ch) + chk_en;
    endfunction

    // Running 8-bit checksum accumulation (modulo-256 sum).
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/telemetry_framer_if.sv
// Byte handshake between the framer and the UART transmitter.
interface telemetry_framer_if;
    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done;

    modport master (output tx_data, output trmt, input tx_done);
    modport slave  (input tx_data, input trmt, output tx_done);
endinterface

// File: rtl/telemetry_framer_timer.sv
// Free-running frame period counter; tick marks the last count of each period.
module telem_period_timer #(
    parameter int unsigned PERIOD = 1048576
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned      CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Reset loads the last count so the first tick lands right after reset release.
    assign tick = (count_q == LAST);

    // Next count: wrap to zero on tick, otherwise increment.
    always_comb begin
        if (tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/telemetry_framer.sv
// Periodic telemetry frame generator: snapshots NUM_CH samples and streams
// DELIM1 DELIM2 SEQ {HI LO}*NUM_CH [CHK] over the trmt/tx_done byte handshake.
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned PERIOD = 1048576,
    parameter int unsigned CHK_EN = 1,
    parameter logic [7:0]  DELIM1 = DELIM1_DEFAULT,
    parameter logic [7:0]  DELIM2 = DELIM2_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    telemetry_framer_if.master       tx_if,
    output logic                     busy,
    output logic                     skip,
    output logic                     overrun
);
    localparam logic       CHK_ON  = (CHK_EN != 0);
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    state_t                    state_q,   state_d;
    logic [2:0]                ch_idx_q,  ch_idx_d;
    logic [7:0]                seq_q,     seq_d;
    logic [7:0]                chk_q,     chk_d;
    logic [NUM_CH*DATA_W-1:0]  snap_q,    snap_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      trmt_q,    trmt_d;
    logic                      busy_q,    busy_d;
    logic                      skip_q,    skip_d;
    logic                      overrun_q, overrun_d;

    logic                      tick_s;
    logic                      tx_done_s;
    logic [2:0]                sel_idx_s;
    logic [DATA_W-1:0]         sel_sample_s;
    logic [7:0]                sel_hi_s;
    logic [7:0]                sel_lo_s;

    // Upper sample bits, zero-extended into a byte.
    function automatic logic [7:0] hi_byte(input logic [DATA_W-1:0] s);
        return 8'(s >> 8);
    endfunction

    telem_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    assign tx_done_s     = tx_if.tx_done;
    assign tx_if.tx_data = tx_data_q;
    assign tx_if.trmt    = trmt_q;
    assign busy          = busy_q;
    assign skip          = skip_q;
    assign overrun       = overrun_q;

    // In S_LO the next byte belongs to the following channel; elsewhere to the current one.
    assign sel_idx_s = (state_q == S_LO) ? (ch_idx_q + 3'd1) : ch_idx_q;
    assign sel_hi_s  = hi_byte(sel_sample_s);
    assign sel_lo_s  = sel_sample_s[7:0];

    // Pick the snapshot sample addressed by sel_idx_s.
    always_comb begin
        sel_sample_s = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            sel_sample_s = (sel_idx_s == 3'(k)) ? snap_q[k*DATA_W +: DATA_W] : sel_sample_s;
        end
    end

    // Frame sequencing, byte loading, checksum and overrun detection.
    always_comb begin
        state_d   = state_q;
        ch_idx_d  = ch_idx_q;
        seq_d     = seq_q;
        chk_d     = chk_q;
        snap_d    = snap_q;
        tx_data_d = tx_data_q;
        trmt_d    = 1'b0;

        if (tick_s && (state_q != IDLE)) begin
            skip_d    = 1'b1;
            overrun_d = 1'b1;
        end else begin
            skip_d    = 1'b0;
            overrun_d = overrun_q;
        end

        case (state_q)
            IDLE: begin
                if (tick_s && en) begin
                    snap_d    = ch_data;
                    tx_data_d = DELIM1;
                    trmt_d    = 1'b1;
                    ch_idx_d  = 3'd0;
                    state_d   = S_D1;
                end else begin
                    state_d   = IDLE;
                end
            end
            S_D1: begin
                if (tx_done_s) begin
                    tx_data_d = DELIM2;
                    trmt_d    = 1'b1;
                    state_d   = S_D2;
                end else begin
                    state_d   = S_D1;
                end
            end
            S_D2: begin
                if (tx_done_s) begin
                    tx_data_d = seq_q;
                    chk_d     = seq_q;
                    trmt_d    = 1'b1;
                    state_d   = S_SEQ;
                end else begin
                    state_d   = S_D2;
                end
            end
            S_SEQ: begin
                if (tx_done_s) begin
                    tx_data_d = sel_hi_s;
                    chk_d     = chk_add(chk_q, sel_hi_s);
                    trmt_d    = 1'b1;
                    ch_idx_d  = 3'd0;
                    state_d   = S_HI;
                end else begin
                    state_d   = S_SEQ;
                end
            end
            S_HI: begin
                if (tx_done_s) begin
                    tx_data_d = sel_lo_s;
                    chk_d     = chk_add(chk_q, sel_lo_s);
                    trmt_d    = 1'b1;
                    state_d   = S_LO;
                end else begin
                    state_d   = S_HI;
                end
            end
            S_LO: begin
                if (tx_done_s) begin
                    if (ch_idx_q != LAST_CH) begin
                        ch_idx_d  = ch_idx_q + 3'd1;
                        tx_data_d = sel_hi_s;
                        chk_d     = chk_add(chk_q, sel_hi_s);
                        trmt_d    = 1'b1;
                        state_d   = S_HI;
                    end else if (CHK_ON) begin
                        tx_data_d = ~chk_q;
                        trmt_d    = 1'b1;
                        state_d   = S_CHK;
                    end else begin
                        seq_d     = seq_q + 8'd1;
                        ch_idx_d  = 3'd0;
                        state_d   = IDLE;
                    end
                end else begin
                    state_d   = S_LO;
                end
            end
            S_CHK: begin
                if (tx_done_s) begin
                    seq_d     = seq_q + 8'd1;
                    ch_idx_d  = 3'd0;
                    state_d   = IDLE;
                end else begin
                    state_d   = S_CHK;
                end
            end
            default: begin
                ch_idx_d = 3'd0;
                state_d  = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_idx_q  <= 3'd0;
            seq_q     <= 8'h00;
            chk_q     <= 8'h00;
            snap_q    <= '0;
            tx_data_q <= 8'h00;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            skip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_idx_q  <= ch_idx_d;
            seq_q     <= seq_d;
            chk_q     <= chk_d;
            snap_q    <= snap_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            busy_q    <= busy_d;
            skip_q    <= skip_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_telemetry_framer.sv
// Scoreboard bench: dut_a (3 ch x 12 bit, checksum, PERIOD 120) covers the
// frame format, snapshot, enable gating, SEQ wrap and mid-frame reset;
// dut_b (1 ch x 16 bit, no checksum, PERIOD 40) covers the width sweep and overrun.
module tb_telemetry_framer;
    import telemetry_pkg::*;

    localparam int FL_A = int'(frame_len(3, 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, en_a, en_b;
    logic [35:0] ch_a;
    logic [15:0] ch_b;
    logic        busy_a, skip_a, ovr_a;
    logic        busy_b, skip_b, ovr_b;

    telemetry_framer_if if_a ();
    telemetry_framer_if if_b ();

    telemetry_framer #(.NUM_CH(3), .DATA_W(12), .PERIOD(120), .CHK_EN(1)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .ch_data(ch_a), .tx_if(if_a),
        .busy(busy_a), .skip(skip_a), .overrun(ovr_a)
    );

    telemetry_framer #(.NUM_CH(1), .DATA_W(16), .PERIOD(40), .CHK_EN(0)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .ch_data(ch_b), .tx_if(if_b),
        .busy(busy_b), .skip(skip_b), .overrun(ovr_b)
    );

    int total = 0;
    int bad   = 0;
    int skips_a = 0;
    int skips_b = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    // Expected frame for dut_a from the byte-order and checksum rules; first nbytes pushed.
    task automatic push_frame_a(input logic [7:0] seq, input logic [35:0] ch, input int nbytes);
        logic [7:0]  b[10];
        logic [7:0]  sum;
        logic [11:0] s;
        b[0] = 8'hAA;
        b[1] = 8'h55;
        b[2] = seq;
        sum  = seq;
        for (int k = 0; k < 3; k++) begin
            s = ch[k*12 +: 12];
            b[3+2*k] = {4'h0, s[11:8]};
            b[4+2*k] = s[7:0];
            sum = sum + b[3+2*k] + b[4+2*k];
        end
        b[9] = ~sum;
        for (int i = 0; i < nbytes; i++) exp_a.push_back(b[i]);
    endtask

    // UART models: tx_done pulses 10 cycles after each trmt.
    int cnt_a = 0;
    always @(negedge clk) begin
        if_a.tx_done = 1'b0;
        if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) if_a.tx_done = 1'b1;
        end
        if (if_a.trmt) cnt_a = 10;
    end

    int cnt_b = 0;
    always @(negedge clk) begin
        if_b.tx_done = 1'b0;
        if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) if_b.tx_done = 1'b1;
        end
        if (if_b.trmt) cnt_b = 10;
    end

    // Monitor A: compare every presented byte against the scoreboard.
    logic prev_trmt_a = 1'b0;
    always @(negedge clk) begin
        if (if_a.trmt) begin
            check("a_trmt_single_cycle", {31'd0, prev_trmt_a}, 32'd0);
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_byte: got %02h, required no byte", if_a.tx_data);
            end else begin
                check("a_byte", {24'd0, if_a.tx_data}, {24'd0, exp_a.pop_front()});
            end
        end
        if (skip_a) skips_a++;
        prev_trmt_a = if_a.trmt;
    end

    // Monitor B.
    logic prev_trmt_b = 1'b0;
    always @(negedge clk) begin
        if (if_b.trmt) begin
            check("b_trmt_single_cycle", {31'd0, prev_trmt_b}, 32'd0);
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_byte: got %02h, required no byte", if_b.tx_data);
            end else begin
                check("b_byte", {24'd0, if_b.tx_data}, {24'd0, exp_b.pop_front()});
            end
        end
        if (skip_b) skips_b++;
        prev_trmt_b = if_b.trmt;
    end

    task automatic wait_trmts_a(input int n, input int bound, input string name);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (if_a.trmt) seen++;
        end
        check(name, seen, n);
    endtask

    task automatic wait_idle_a(input int bound, input string name);
        int cyc = 0;
        while ((exp_a.size() != 0 || busy_a) && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (exp_a.size() != 0 || busy_a) begin
            bad++;
            $display("FAIL %s: %0d bytes outstanding, busy=%0b after %0d cycles, required 0 and 0",
                     name, exp_a.size(), busy_a, cyc);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b1;
        ch_a  = {12'hFFF, 12'h123, 12'hABC};
        ch_b  = 16'hBEEF;
        repeat (3) @(negedge clk);

        check("rst_tx_data", {24'd0, if_a.tx_data}, 32'h00);
        check("rst_trmt",    {31'd0, if_a.trmt},    32'd0);
        check("rst_busy",    {31'd0, busy_a},       32'd0);
        check("rst_skip",    {31'd0, skip_a},       32'd0);
        check("rst_overrun", {31'd0, ovr_a},        32'd0);
        check("rst_b_overrun", {31'd0, ovr_b},      32'd0);

        // dut_b: 5-byte frames of 56 cycles against a 40-cycle period.
        // Frames start on even ticks (0,40..) -> ticks 0,80,160,240; odd ticks skip.
        for (int f = 0; f < 4; f++) begin
            exp_b.push_back(8'hAA); exp_b.push_back(8'h55); exp_b.push_back(8'(f));
            exp_b.push_back(8'hBE); exp_b.push_back(8'hEF);
        end
        rst_b = 1'b0;
        repeat (250) @(negedge clk);
        en_b = 1'b0;           // tick 280 still skips while busy, en is ignored
        repeat (170) @(negedge clk);
        check("b_skip_count",  skips_b, 4);
        check("b_overrun",     {31'd0, ovr_b},  32'd1);
        check("b_busy_end",    {31'd0, busy_b}, 32'd0);
        check("b_bytes_left",  exp_b.size(), 0);

        // Basic frame; ch_data cleared after DELIM1 must not reach the frame.
        exp_a.push_back(8'hAA); exp_a.push_back(8'h55); exp_a.push_back(8'h00);
        exp_a.push_back(8'h0A); exp_a.push_back(8'hBC); exp_a.push_back(8'h01);
        exp_a.push_back(8'h23); exp_a.push_back(8'h0F); exp_a.push_back(8'hFF);
        exp_a.push_back(8'h07);
        rst_a = 1'b0;
        wait_trmts_a(1, 20, "a_first_start");
        ch_a = '0;
        wait_idle_a(200, "a_basic_done");
        check("a_basic_busy_low", {31'd0, busy_a}, 32'd0);

        // Enable gating: two ticks pass with en low -> no bytes, no skip.
        en_a = 1'b0;
        ch_a = {12'h987, 12'h0F0, 12'h5A5};
        repeat (130) @(negedge clk);
        check("a_en0_no_skip", skips_a, 0);
        check("a_en0_idle", {31'd0, busy_a}, 32'd0);

        // Second frame, en dropped right after DELIM1: it must still complete.
        exp_a.push_back(8'hAA); exp_a.push_back(8'h55); exp_a.push_back(8'h01);
        exp_a.push_back(8'h05); exp_a.push_back(8'hA5); exp_a.push_back(8'h00);
        exp_a.push_back(8'hF0); exp_a.push_back(8'h09); exp_a.push_back(8'h87);
        exp_a.push_back(8'hD4);
        en_a = 1'b1;
        wait_trmts_a(1, 130, "a_en1_start");
        en_a = 1'b0;
        wait_idle_a(200, "a_en_mid_frame_done");

        // SEQ wrap: frames with SEQ 02..FF then 00 (257 frames since reset).
        ch_a = {12'h001, 12'h7FF, 12'h800};
        for (int i = 2; i <= 256; i++) push_frame_a(8'(i), ch_a, FL_A);
        en_a = 1'b1;
        begin
            int cyc = 0;
            while (exp_a.size() > FL_A - 1 && cyc < 255 * 120 + 300) begin
                @(negedge clk);
                cyc++;
            end
        end
        en_a = 1'b0;
        wait_idle_a(300, "a_seq_wrap_done");
        check("a_wrap_no_skip", skips_a, 0);

        // Mid-frame reset once HI_0 is in flight (SEQ is 01 after the wrap).
        push_frame_a(8'h01, ch_a, 4);
        en_a = 1'b1;
        wait_trmts_a(4, 250, "a_reach_hi");
        rst_a = 1'b1;
        @(negedge clk);
        check("a_midrst_trmt",    {31'd0, if_a.trmt},    32'd0);
        check("a_midrst_tx_data", {24'd0, if_a.tx_data}, 32'h00);
        check("a_midrst_busy",    {31'd0, busy_a},       32'd0);
        repeat (15) @(negedge clk);
        check("a_midrst_bytes_left", exp_a.size(), 0);

        // Restart after reset: SEQ back to 00.
        push_frame_a(8'h00, ch_a, FL_A);
        rst_a = 1'b0;
        wait_idle_a(200, "a_restart_done");
        check("a_final_overrun", {31'd0, ovr_a}, 32'd0);
        check("a_final_skips", skips_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
